// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared states, line symbols, SYNC pattern and pin decoding for the USB transmitter
package usb_tx_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP_SE0, ST_EOP_J} state_t;
  typedef enum logic [1:0] {LINE_J, LINE_K, LINE_SE0} line_t;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  // returns {dplus, dminus}; low speed swaps which pin is high for J
  function automatic logic [1:0] line_pins(input line_t l, input logic low_speed);
    return l == LINE_SE0 ? 2'b00 : ((l == LINE_J) ^ low_speed) ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/usb_bit_timer.sv
// usb_bit_timer: bit-period counter with a one-cycle rollover flag
//   clk, rst       : clock, async active-high reset
//   clear          : restart the period at count 0 on the next cycle
//   rollover_flag  : high while the count sits at CLKS_PER_BIT-1 (the bit boundary)
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic rollover_flag
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] count;
  assign rollover_flag = count == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= clear || rollover_flag ? '0 : count + 1'b1;
endmodule

// File: rtl/usb_nrzi_tx_serializer.sv
// usb_nrzi_tx_serializer: USB LS/FS transmit encoder (SYNC, LSB-first serialize, bit stuffing, NRZI, EOP)
//   tx_data/tx_valid/tx_last/tx_ready : byte handshake from the packet builder
//   dplus/dminus/tx_oe                : registered pad drive and output enable
//   busy                              : a packet is in flight
//   underrun                          : one-cycle pulse when a non-last byte ends with no byte held
module usb_nrzi_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int EOP_SE0_BITS = 2,
  parameter int STUFF_LEN    = 6,
  parameter bit LOW_SPEED    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dplus,
  output logic       dminus,
  output logic       tx_oe,
  output logic       busy,
  output logic       underrun
);
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int EW = $clog2(EOP_SE0_BITS + 1);
  state_t state, state_n;
  line_t line, line_n;
  logic [7:0] hold_data, shreg;
  logic hold_last, hold_full, sh_last;
  logic [3:0] cnt;
  logic [OW-1:0] ones;
  logic [EW-1:0] eop_cnt;
  logic tick, accept, start, shifting, stuff_due, done, load, finish, send, sbit, se0_end, j_end;
  usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) timer (.clk(clk), .rst(rst), .clear(start), .rollover_flag(tick));
  assign tx_ready = !hold_full && state inside {ST_IDLE, ST_SYNC, ST_DATA};
  assign accept = tx_valid && tx_ready;
  // a byte left in hold after the previous packet starts the next one
  assign start = state == ST_IDLE && (accept || hold_full);
  assign shifting = tick && state inside {ST_SYNC, ST_DATA};
  assign stuff_due = ones == OW'(STUFF_LEN);
  // cnt counts bits of the current byte already on the line; 8 means the byte is spent
  assign done = shifting && !stuff_due && cnt[3];
  assign load = done && !sh_last && hold_full;
  assign finish = done && !load;
  assign send = shifting && !finish;
  assign sbit = stuff_due ? 1'b0 : load ? hold_data[0] : shreg[cnt[2:0]];
  assign se0_end = tick && state == ST_EOP_SE0 && eop_cnt == EW'(EOP_SE0_BITS);
  assign j_end = tick && state == ST_EOP_J;
  assign underrun = finish && !sh_last;
  assign busy = state != ST_IDLE;
  assign line_n = start ? LINE_K : send ? (sbit ? line : line == LINE_J ? LINE_K : LINE_J) :
                  finish ? LINE_SE0 : se0_end ? LINE_J : line;
  assign state_n = start ? ST_SYNC : load ? ST_DATA : finish ? ST_EOP_SE0 : se0_end ? ST_EOP_J :
                   j_end ? ST_IDLE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      line <= LINE_J;
      {dplus, dminus} <= line_pins(LINE_J, LOW_SPEED);
      tx_oe <= 1'b0;
      hold_data <= '0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      shreg <= '0;
      sh_last <= 1'b0;
      cnt <= '0;
      ones <= '0;
      eop_cnt <= '0;
    end else begin
      state <= state_n;
      line <= line_n;
      {dplus, dminus} <= line_pins(line_n, LOW_SPEED);
      tx_oe <= start || (tx_oe && !j_end);
      hold_full <= accept || (hold_full && !load);
      if (accept) {hold_data, hold_last} <= {tx_data, tx_last};
      shreg <= start ? SYNC_BYTE : load ? hold_data : shreg;
      sh_last <= start ? 1'b0 : load ? hold_last : sh_last;
      cnt <= start || load ? 4'd1 : send && !stuff_due ? cnt + 4'd1 : cnt;
      ones <= start ? '0 : send ? (sbit ? ones + 1'b1 : '0) : ones;
      eop_cnt <= finish ? EW'(1) : tick && state == ST_EOP_SE0 ? eop_cnt + 1'b1 : eop_cnt;
    end
endmodule
